// File: rtl/main_mem_model_pkg.sv
// ---------------------------------------------------------------------------
// main_mem_model_pkg
// Shared definitions for the main memory model: FSM state encoding, default
// geometry and latencies, and a saturating-increment helper for the stats.
// ---------------------------------------------------------------------------
package main_mem_model_pkg;

  // Request FSM: wait, count latency, pulse ready, mandatory idle gap
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2,
    GAP  = 2'd3
  } memState_e;

  // Upper end of the cache's cacheable window; the default memory covers it
  localparam logic [31:0] CACHEABLE_LIMIT   = 32'h0001_0000;
  localparam int unsigned DEF_MEM_WORDS     = CACHEABLE_LIMIT >> 2;
  localparam int unsigned DEF_READ_LATENCY  = 4;
  localparam int unsigned DEF_WRITE_LATENCY = 4;

  // Width of the latency down-counter
  localparam int unsigned LAT_W = 16;

  // Counters stick at all-ones instead of wrapping
  function automatic logic [31:0] satInc(input logic [31:0] value);
    return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/main_mem_model_if.sv
// ---------------------------------------------------------------------------
// main_mem_model_if
// Request/ready bus between the direct-mapped cache (master) and main memory
// (slave).
//   mem_valid_mem  master->slave  request valid
//   mem_instr_mem  master->slave  instruction-fetch tag
//   mem_addr_mem   master->slave  byte address, bits [1:0] ignored
//   mem_wdata_mem  master->slave  write data
//   mem_wstrb_mem  master->slave  byte strobes, 0 = read
//   mem_ready_mem  slave->master  one-cycle completion pulse
//   mem_rdata_mem  slave->master  read data, valid with ready
//   mem_err        slave->master  out-of-range flag, pulses with ready
// ---------------------------------------------------------------------------
interface main_mem_model_if;

  logic        mem_valid_mem;
  logic        mem_instr_mem;
  logic [31:0] mem_addr_mem;
  logic [31:0] mem_wdata_mem;
  logic [3:0]  mem_wstrb_mem;
  logic        mem_ready_mem;
  logic [31:0] mem_rdata_mem;
  logic        mem_err;

  modport master (
    output mem_valid_mem, mem_instr_mem, mem_addr_mem, mem_wdata_mem, mem_wstrb_mem,
    input  mem_ready_mem, mem_rdata_mem, mem_err
  );

  modport slave (
    input  mem_valid_mem, mem_instr_mem, mem_addr_mem, mem_wdata_mem, mem_wstrb_mem,
    output mem_ready_mem, mem_rdata_mem, mem_err
  );

endinterface

// File: rtl/main_mem_model_word_array.sv
// ---------------------------------------------------------------------------
// mem_word_array
// WORDS x 32-bit synchronous RAM with four byte-lane write enables and a
// registered read port.  Contents are not touched by reset; only the read
// register is cleared.  INIT_FILE names the power-up image for the flow.
//   clk      in   clock, rising edge
//   reset    in   asynchronous active-low reset (read register only)
//   rdEn_i   in   load read register from idx_i at this edge
//   wrEn_i   in   per-byte write enables
//   idx_i    in   word index
//   wdata_i  in   write data
//   rdata_o  out  registered read data
// ---------------------------------------------------------------------------
module mem_word_array #(
  parameter int unsigned WORDS     = 16384,
  parameter int unsigned AW        = 14,
  parameter string       INIT_FILE = ""
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          rdEn_i,
  input  logic [3:0]    wrEn_i,
  input  logic [AW-1:0] idx_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [WORDS];
  logic [31:0] rdata_q;

  // Byte-lane writes; lanes with a cleared enable keep their old contents
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (wrEn_i[b]) begin
        mem_q[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  // Read register only changes on a read so it holds across writes
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata_q <= 32'h0;
    end else if (rdEn_i) begin
      rdata_q <= mem_q[idx_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/main_mem_model.sv
// ---------------------------------------------------------------------------
// main_mem_model
// Word-addressed main memory behind the direct-mapped cache.  Each request
// completes after a programmable latency with a one-cycle ready pulse,
// followed by one idle gap cycle.  Out-of-range accesses still complete but
// raise mem_err and never touch the array.
// Optional macro MEM_STATS_EN enables saturating read/write/ifetch counters;
// without it the stat outputs are tied to zero.
//   clk          in   clock, rising edge
//   reset        in   asynchronous active-low reset
//   bus          slave side of main_mem_model_if
//   stat_reads   out  completed in-range reads
//   stat_writes  out  completed in-range writes
//   stat_ifetch  out  completed in-range reads tagged as instruction fetch
// ---------------------------------------------------------------------------
module main_mem_model
  import main_mem_model_pkg::*;
#(
  parameter int unsigned MEM_WORDS     = DEF_MEM_WORDS,
  parameter int unsigned READ_LATENCY  = DEF_READ_LATENCY,
  parameter int unsigned WRITE_LATENCY = DEF_WRITE_LATENCY,
  parameter string       INIT_FILE     = ""
) (
  input  logic              clk,
  input  logic              reset,
  main_mem_model_if.slave   bus,
  output logic [31:0]       stat_reads,
  output logic [31:0]       stat_writes,
  output logic [31:0]       stat_ifetch
);

  localparam int unsigned AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [33:0] BYTE_LIMIT = 34'(MEM_WORDS) * 34'd4;
  localparam logic [LAT_W-1:0] RD_LAT = LAT_W'(READ_LATENCY);
  localparam logic [LAT_W-1:0] WR_LAT = LAT_W'(WRITE_LATENCY);

  memState_e        state_q, state_d;
  logic [LAT_W-1:0] cnt_q, cnt_d;
  logic [LAT_W-1:0] reqLat;
  logic             err_q;
  logic             rdZero_q;
  logic             launch;
  logic             inRange;
  logic             isWrite;
  logic             rdEn;
  logic [3:0]       wrEn;
  logic [31:0]      arrayRdata;

  // Full 32-bit compare so high address bits can never alias into the array
  assign inRange = ({2'b00, bus.mem_addr_mem} < BYTE_LIMIT);
  assign isWrite = (bus.mem_wstrb_mem != 4'b0000);

  // Next state and latency count; launch marks the edge that raises ready,
  // which is where the request is actually sampled and performed
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    launch  = 1'b0;
    reqLat  = isWrite ? WR_LAT : RD_LAT;
    case (state_q)
      IDLE: begin
        if (bus.mem_valid_mem) begin
          if (reqLat <= 1) begin
            launch  = 1'b1;
            state_d = RESP;
          end else begin
            cnt_d   = reqLat - 1'b1;
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        if (!bus.mem_valid_mem) begin
          state_d = IDLE;
        end else if (cnt_q <= 1) begin
          launch  = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP:    state_d = GAP;
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, counter, error flag and the "last read was out of range" marker
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      rdZero_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= launch & ~inRange;
      if (launch && !isWrite) begin
        rdZero_q <= ~inRange;
      end
    end
  end

  // Array accesses are gated by reset so a request pending at reset is lost
  assign rdEn = launch & ~isWrite & inRange & reset;
  assign wrEn = (launch && isWrite && inRange && reset) ? bus.mem_wstrb_mem : 4'b0000;

  mem_word_array #(
    .WORDS     (MEM_WORDS),
    .AW        (AW),
    .INIT_FILE (INIT_FILE)
  ) u_array (
    .clk     (clk),
    .reset   (reset),
    .rdEn_i  (rdEn),
    .wrEn_i  (wrEn),
    .idx_i   (bus.mem_addr_mem[AW+1:2]),
    .wdata_i (bus.mem_wdata_mem),
    .rdata_o (arrayRdata)
  );

  assign bus.mem_ready_mem = (state_q == RESP);
  assign bus.mem_err       = err_q;
  assign bus.mem_rdata_mem = rdZero_q ? 32'h0 : arrayRdata;

`ifdef MEM_STATS_EN
  logic        respWrite_q;
  logic [31:0] statReads_q, statWrites_q, statIfetch_q;

  // Remember the direction of the request being answered
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      respWrite_q <= 1'b0;
    end else if (launch) begin
      respWrite_q <= isWrite;
    end
  end

  // Count in the ready cycle; out-of-range completions are excluded
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      statReads_q  <= 32'h0;
      statWrites_q <= 32'h0;
      statIfetch_q <= 32'h0;
    end else if (state_q == RESP && !err_q) begin
      if (respWrite_q) begin
        statWrites_q <= satInc(statWrites_q);
      end else begin
        statReads_q <= satInc(statReads_q);
        if (bus.mem_instr_mem) begin
          statIfetch_q <= satInc(statIfetch_q);
        end
      end
    end
  end

  assign stat_reads  = statReads_q;
  assign stat_writes = statWrites_q;
  assign stat_ifetch = statIfetch_q;
`else
  assign stat_reads  = 32'h0;
  assign stat_writes = 32'h0;
  assign stat_ifetch = 32'h0;
`endif

endmodule
